cipher_word_display: RTL and testbench
======================================

# cipher_word_display

Parametrised, time-multiplexed seven-segment controller for the cipher demo board. It holds a writable table of NUM_WORDS words, each WORD_LEN 4-bit symbols long, and shows the word chosen by `s` on NUM_DIGITS common-anode digits. In static mode it shows the first NUM_DIGITS symbols; in scroll mode it slides a window across the word with wrap-around. It replaces the fixed four-letter mux-plus-display arrangement and drives the board `an`/`sseg` pins directly.

## Interface
Parameters:
- NUM_DIGITS, 4, number of physical digits scanned (≥1).
- NUM_WORDS, 4, words in the symbol table (≥2).
- WORD_LEN, 8, symbols per word (≥NUM_DIGITS).
- REFRESH_DIV, 50000, clk cycles per digit slot.
- SCROLL_DIV, 25000000, clk cycles per scroll step.
- DP_MASK, all ones, per-digit decimal-point enable, active-low, width NUM_DIGITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s  in  $clog2(NUM_WORDS)  selected word index.
- mode  in  1  0 = static, 1 = scroll.
- wr_en  in  1  write strobe for the symbol table.
- wr_word  in  $clog2(NUM_WORDS)  word to write.
- wr_pos  in  $clog2(WORD_LEN)  symbol position to write.
- wr_sym  in  4  symbol value to write.
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-zero.
- sseg  out  8  segments {dp,g..a}, active-low.

## Operation
- Symbol table: NUM_WORDS×WORD_LEN×4-bit registers, all reset to 4'h0.
  - With wr_en high, the addressed entry updates at the next edge.
  - Writes with wr_pos ≥ WORD_LEN are ignored.
  - Writes are legal in any mode, at any time.
- Refresh counter: 0..REFRESH_DIV-1; wraps to 0. `tick_r` is asserted when the count equals REFRESH_DIV-1.
  - On tick_r, the scan index advances 0..NUM_DIGITS-1 and wraps.
- Scroll counter: 0..SCROLL_DIV-1; `tick_s` is asserted at the terminal count.
  - In mode=1, tick_s sets offset ← (offset+1) mod WORD_LEN.
  - In mode=0, offset is held at 0 and the scroll counter is held at 0.
- Word change:
  - If `s` differs from its registered copy, offset ← 0 and the scroll counter ← 0 at the next edge.
  - This takes priority over tick_s in the same cycle.
- Digit mapping: digit d (an[d]; d=NUM_DIGITS-1 is leftmost) shows symbol at (offset + NUM_DIGITS-1-d) mod WORD_LEN of word s. The leftmost digit therefore shows the first symbol.
- Decode: hex 0-F mapped to standard active-low patterns. dp = DP_MASK[d].
- Mode 1→0 sets offset to 0 at the next edge.

## Timing
- Reset (synchronous, dominant over all else):
  - an = all ones (all digits off), sseg = 8'hFF.
  - Counters, scan index and offset = 0.
  - Table cleared.
- After reset deasserts:
  - First display update occurs on the edge after the first tick_r.
  - That update drives scan index 1. Index 0 is first lit after a full scan.
- an and sseg are registered together and change on the same edge. They never show mismatched digit/segment pairs.
- Latency: a table write or offset change appears on a digit the next time that digit is scanned, i.e. within NUM_DIGITS×REFRESH_DIV+1 cycles.
- Wrap-around:
  - Offset WORD_LEN-1 → 0.
  - Digit positions past WORD_LEN-1 wrap to 0, so the window spans the end of the word seamlessly.
- Simultaneous events:
  - tick_r and tick_s in the same cycle are both applied.
  - A write to the entry currently being latched: the old value is shown this slot and the new value next slot.
- Reset mid-scan blanks the outputs at the next edge.

## Structure
- Shared package cipher_disp_pkg:
  - typedef sym_t (logic [3:0]).
  - typedef sseg_t (logic [7:0]).
  - SSEG_BLANK = 8'hFF.
  - function hex_to_sseg(sym_t) returning sseg_t (active-low, dp bit 7 = 1).
- One natural sub-module: disp_scan_timer. It contains the refresh counter and scan index, is parameterised by NUM_DIGITS and REFRESH_DIV, and outputs scan index and tick_r.
- Everything else stays in cipher_word_display.

## Test plan
Run with REFRESH_DIV=4, SCROLL_DIV=16, NUM_DIGITS=4, WORD_LEN=8.
- Reset held 3 cycles with counters mid-count -> an=4'hF, sseg=8'hFF on the cycle after the reset edge; all digits read symbol 0 (sseg 8'hC0) after one full scan.
- Write word 1 = 3,2,4,5,6,7,8,9; s=1, mode=0 -> an=4'b0111 shows 3 (8'hB0); an=4'b1110 shows 5 (8'h92); an changes every 4 cycles.
- mode=1, word 1 as above -> after the first tick_s the leftmost digit shows 2. After 7 scroll steps the digits show 9,3,2,4 (wrap).
- Change s from 1 to 0 in the same cycle as tick_s -> offset=0 next edge; leftmost digit shows word 0 symbol 0.
- Write with wr_pos=8 (out of range for WORD_LEN=8, using an 8-bit-capable pos bench variant) -> table unchanged. Write to the currently displayed symbol -> new value appears on the next scan of that digit, not earlier.
- Assert reset during scroll offset 5 -> outputs blank next edge; after release, offset=0 and no stale symbols appear.

Source files
------------

// File: rtl/cipher_disp_pkg.sv
// Shared types and the hex-to-segment decoder for the cipher word display.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} with dp left off.
package cipher_disp_pkg;

  typedef logic [3:0] sym_t;
  typedef logic [7:0] sseg_t;

  localparam sseg_t SSEG_BLANK = 8'hFF;

  function automatic sseg_t hex_to_sseg(input sym_t sym);
    sseg_t seg;
    seg = SSEG_BLANK;
    case (sym)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SSEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Digit refresh timer: counts REFRESH_DIV cycles per slot and steps the
// scan index through 0..NUM_DIGITS-1 on each terminal count.
module disp_scan_timer #(
  parameter int  NUM_DIGITS  = 4,
  parameter int  REFRESH_DIV = 50000,
  localparam int IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] scan_idx_o,
  output logic          tick_r_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick_r;

  assign tick_r = (cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick_r) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign scan_idx_o = idx_q;
  assign tick_r_o   = tick_r;

endmodule

// File: rtl/cipher_word_display.sv
// Time-multiplexed seven-segment driver showing one word of a writable
// symbol table, either statically or as a wrapping scrolling window.
module cipher_word_display
  import cipher_disp_pkg::*;
#(
  parameter int                    NUM_DIGITS  = 4,
  parameter int                    NUM_WORDS   = 4,
  parameter int                    WORD_LEN    = 8,
  parameter int                    REFRESH_DIV = 50000,
  parameter int                    SCROLL_DIV  = 25000000,
  parameter logic [NUM_DIGITS-1:0] DP_MASK     = '1,
  parameter int                    WPOS_W      = $clog2(WORD_LEN),
  localparam int                   SW          = $clog2(NUM_WORDS),
  localparam int                   PW          = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1,
  localparam int                   IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int                   CW          = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW-1:0]         s,
  input  logic                  mode,
  input  logic                  wr_en,
  input  logic [SW-1:0]         wr_word,
  input  logic [WPOS_W-1:0]     wr_pos,
  input  sym_t                  wr_sym,
  output logic [NUM_DIGITS-1:0] an,
  output sseg_t                 sseg
);

  sym_t                  sym_tab_q [NUM_WORDS][WORD_LEN];
  logic                  wr_ok;
  logic [PW-1:0]         offset_q, offset_d;
  logic [CW-1:0]         scnt_q, scnt_d;
  logic [SW-1:0]         s_q;
  logic                  tick_s;
  logic [IW-1:0]         scan_idx, scan_next;
  logic                  tick_r;
  logic [PW:0]           pos_raw, pos_wrap;
  sym_t                  sym_cur;
  sseg_t                 seg_raw;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  sseg_t                 sseg_q, sseg_d;

  disp_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .scan_idx_o(scan_idx),
    .tick_r_o  (tick_r)
  );

  assign wr_ok = wr_en && (32'(wr_pos) < WORD_LEN) && (32'(wr_word) < NUM_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WORDS; w++)
        for (int p = 0; p < WORD_LEN; p++)
          sym_tab_q[w][p] <= '0;
    end else if (wr_ok) begin
      sym_tab_q[wr_word][wr_pos[PW-1:0]] <= wr_sym;
    end
  end

  // A word change or static mode restarts the scroll window from symbol 0.
  assign tick_s = mode && (scnt_q == CW'(SCROLL_DIV - 1));

  always_comb begin
    scnt_d   = scnt_q + 1'b1;
    offset_d = offset_q;
    if (!mode || (s != s_q)) begin
      scnt_d   = '0;
      offset_d = '0;
    end else if (tick_s) begin
      scnt_d   = '0;
      offset_d = (offset_q == PW'(WORD_LEN - 1)) ? '0 : offset_q + 1'b1;
    end
  end

  // The output register latches the digit the scan is about to enter, so
  // an and sseg always move together on the refresh tick.
  always_comb begin
    scan_next = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    pos_raw   = {1'b0, offset_q} + (PW+1)'(NUM_DIGITS - 1 - int'(scan_next));
    pos_wrap  = (pos_raw >= (PW+1)'(WORD_LEN)) ? pos_raw - (PW+1)'(WORD_LEN) : pos_raw;
    sym_cur   = sym_tab_q[s][pos_wrap[PW-1:0]];
    seg_raw   = hex_to_sseg(sym_cur);
    an_d      = '1;
    an_d[scan_next] = 1'b0;
    sseg_d    = {DP_MASK[scan_next], seg_raw[6:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q     <= '1;
      sseg_q   <= SSEG_BLANK;
      offset_q <= '0;
      scnt_q   <= '0;
      s_q      <= s;
    end else begin
      offset_q <= offset_d;
      scnt_q   <= scnt_d;
      s_q      <= s;
      if (tick_r) begin
        an_q   <= an_d;
        sseg_q <= sseg_d;
      end
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_cipher_word_display.sv
// Bench for cipher_word_display: directed scenarios plus random traffic,
// all compared against a cycle-count based behavioural model.
module tb_cipher_word_display;

  localparam int ND = 4;
  localparam int WL = 8;
  localparam int RD = 4;
  localparam int SD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] s = 2'd1;
  logic [1:0] wr_word = '0;
  logic [3:0] wr_pos = '0;
  logic [3:0] wr_sym = '0;
  logic [3:0] an;
  logic [7:0] sseg;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] word0_v [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
  logic [3:0] word1_v [8] = '{4'h3, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};

  always #5 clk = ~clk;

  cipher_word_display #(
    .NUM_DIGITS (ND),
    .NUM_WORDS  (4),
    .WORD_LEN   (WL),
    .REFRESH_DIV(RD),
    .SCROLL_DIV (SD),
    .DP_MASK    (4'hF),
    .WPOS_W     (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .s      (s),
    .mode   (mode),
    .wr_en  (wr_en),
    .wr_word(wr_word),
    .wr_pos (wr_pos),
    .wr_sym (wr_sym),
    .an     (an),
    .sseg   (sseg)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: refresh phase and scroll offset derived from edge counts.
  logic [3:0] m_tab [4][8];
  logic [3:0] m_an;
  logic [7:0] m_sseg;
  logic [1:0] m_sprev;
  int         m_rt = 0;
  int         m_ep = 0;
  bit         m_valid = 0;
  int         m_off, m_slot;

  always @(posedge clk) begin
    m_off = (m_ep / SD) % WL;
    if (reset) begin
      m_valid = 1;
      m_an    = 4'hF;
      m_sseg  = 8'hFF;
      m_rt    = 0;
      m_ep    = 0;
      m_sprev = s;
      for (int w = 0; w < 4; w++)
        for (int p = 0; p < WL; p++)
          m_tab[w][p] = 4'h0;
    end else begin
      if (m_rt % RD == RD - 1) begin
        m_slot = ((m_rt + 1) / RD) % ND;
        m_an   = ~(4'b0001 << m_slot);
        m_sseg = seg_lut[m_tab[s][(m_off + ND - 1 - m_slot) % WL]];
      end
      if (wr_en && int'(wr_pos) < WL) m_tab[wr_word][wr_pos[2:0]] = wr_sym;
      if (!mode || s != m_sprev) m_ep = 0;
      else m_ep++;
      m_sprev = s;
      m_rt++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("an_model", {4'h0, an}, {4'h0, m_an});
      chk("sseg_model", sseg, m_sseg);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after an becomes target.
  task automatic wait_an(input logic [3:0] target, input string tag);
    bit hit;
    logic [3:0] prev;
    hit = 0;
    for (int i = 0; i < 64; i++) begin
      prev = an;
      @(negedge clk);
      if (an === target && prev !== target) begin
        hit = 1;
        break;
      end
    end
    chk({tag, "_found"}, {7'b0, hit}, 8'h01);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset   = ($urandom_range(999) < 3);
      wr_en   = ($urandom_range(99) < 30);
      wr_word = 2'($urandom_range(3));
      wr_pos  = 4'($urandom_range(9));
      wr_sym  = 4'($urandom);
      if ($urandom_range(199) < 1) s = 2'($urandom_range(3));
      if ($urandom_range(199) < 1) mode = ~mode;
    end
    @(negedge clk);
    reset = 0;
    wr_en = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0] prev_an;

    cycles(2);
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_sseg", sseg, 8'hFF);
    reset = 0;

    rand_phase(600);

    // Reset held 3 cycles from a mid-count state.
    reset = 1; wr_en = 0; mode = 0; s = 2'd1;
    cycles(1);
    chk("rst3_an", {4'h0, an}, 8'h0F);
    chk("rst3_sseg", sseg, 8'hFF);
    cycles(2);
    reset = 0;
    cycles(3);
    chk("pre_tick_an", {4'h0, an}, 8'h0F);
    cycles(1);
    chk("first_idx_an", {4'h0, an}, 8'h0D);
    chk("first_idx_sseg", sseg, 8'hC0);
    wait_an(4'b1011, "clr_d2");  chk("clr_d2", sseg, 8'hC0);
    wait_an(4'b0111, "clr_d3");  chk("clr_d3", sseg, 8'hC0);
    wait_an(4'b1110, "clr_d0");  chk("clr_d0", sseg, 8'hC0);

    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_word = 2'd1; wr_pos = 4'(i); wr_sym = word1_v[i];
      @(negedge clk);
      wr_word = 2'd0; wr_sym = word0_v[i];
      @(negedge clk);
    end
    wr_en = 0;

    // Static mode on word 1.
    wait_an(4'b0111, "st_d3");  chk("st_d3", sseg, 8'hB0);
    wait_an(4'b1110, "st_d0");  chk("st_d0", sseg, 8'h92);
    prev_an = an;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (an !== prev_an) break;
    end
    chk("refresh_period", 8'(cnt), 8'd4);

    // Scroll mode, aligned to a digit-0 latch (edge E0).
    wait_an(4'b1110, "sc_sync");
    mode = 1;
    cycles(28);
    chk("sc1_an", {4'h0, an}, 8'h07);  chk("sc1_sseg", sseg, 8'hA4);
    cycles(88);
    chk("sc7_d1_an", {4'h0, an}, 8'h0D);  chk("sc7_d1", sseg, 8'hA4);
    cycles(4);
    chk("sc7_d2_an", {4'h0, an}, 8'h0B);  chk("sc7_d2", sseg, 8'hB0);
    cycles(4);
    chk("sc7_d3_an", {4'h0, an}, 8'h07);  chk("sc7_d3", sseg, 8'h90);
    cycles(4);
    chk("sc7_d0_an", {4'h0, an}, 8'h0E);  chk("sc7_d0", sseg, 8'h99);

    // Word change coinciding with the scroll tick at E0+144.
    cycles(15);
    s = 2'd0;
    cycles(9);
    chk("wc_d2_an", {4'h0, an}, 8'h0B);  chk("wc_d2", sseg, 8'h83);
    cycles(4);
    chk("wc_d3_an", {4'h0, an}, 8'h07);  chk("wc_d3", sseg, 8'h88);

    // Out-of-range position is ignored.
    mode = 0;
    wr_en = 1; wr_word = 2'd0; wr_pos = 4'd8; wr_sym = 4'h5;
    cycles(1);
    wr_en = 0;
    wait_an(4'b0111, "oor");  chk("oor_sseg", sseg, 8'h88);

    // Write to the symbol latched on the same edge.
    wait_an(4'b1011, "ws_sync");
    cycles(3);
    wr_en = 1; wr_word = 2'd0; wr_pos = 4'd0; wr_sym = 4'h7;
    cycles(1);
    wr_en = 0;
    chk("ws_old_an", {4'h0, an}, 8'h07);  chk("ws_old", sseg, 8'h88);
    cycles(16);
    chk("ws_new_an", {4'h0, an}, 8'h07);  chk("ws_new", sseg, 8'hF8);

    // Reset while scrolled to offset 5.
    mode = 1;
    cycles(SD * 5 + 2);
    reset = 1;
    cycles(1);
    chk("rs5_an", {4'h0, an}, 8'h0F);  chk("rs5_sseg", sseg, 8'hFF);
    reset = 0;
    cycles(4);
    chk("rs5_first_an", {4'h0, an}, 8'h0D);  chk("rs5_first", sseg, 8'hC0);
    wait_an(4'b1011, "rs5_d2");  chk("rs5_d2", sseg, 8'hC0);
    wait_an(4'b0111, "rs5_d3");  chk("rs5_d3", sseg, 8'hC0);
    wait_an(4'b1110, "rs5_d0");  chk("rs5_d0", sseg, 8'hC0);

    rand_phase(1500);
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
